// File: rtl/tiled_router_controller_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared types and constants for the tiled row-router successor sequencer.
//   state_t         : sequencer FSM states
//   coord_t         : one issued coordinate {x, y, ch, row_id} at default widths
//   row_id_width()  : width of a row-router index, never less than 1 bit
// Optional feature macro used by the top: TILED_ROUTER_CTRL_PERF_EN
// -----------------------------------------------------------------------------
package router_pkg;

   // A single row router still needs a 1-bit index, so $clog2(1)=0 is clamped.
   function automatic int row_id_width(input int row_count);
      return (row_count > 1) ? $clog2(row_count) : 1;
   endfunction

   localparam int ROW_COUNT_DEF    = 4;
   localparam int ADDR_WIDTH_DEF   = 8;
   localparam int CH_WIDTH_DEF     = 4;
   localparam int ROW_ID_WIDTH_DEF = row_id_width(ROW_COUNT_DEF);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      GEN,
      COMPARE,
      DRAIN,
      CLEAR,
      DONE
   } state_t;

   typedef struct packed {
      logic [ADDR_WIDTH_DEF-1:0]   x;
      logic [ADDR_WIDTH_DEF-1:0]   y;
      logic [CH_WIDTH_DEF-1:0]     ch;
      logic [ROW_ID_WIDTH_DEF-1:0] row_id;
   } coord_t;

endpackage

// File: rtl/tiled_router_controller_if.sv
// -----------------------------------------------------------------------------
// tiled_router_controller_if
// Coordinate handshake between the sequencer and the address generator.
//   o_coord_valid : coordinate valid (sequencer -> address generator)
//   i_coord_ready : coordinate accepted (address generator -> sequencer)
//   o_o_x, o_o_y  : output-map coordinate
//   o_ch          : channel index
//   o_row_id      : target row router
// Modports: master = sequencer side, slave = address generator side.
// -----------------------------------------------------------------------------
interface tiled_router_controller_if
   import router_pkg::*;
#(
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int CH_WIDTH     = CH_WIDTH_DEF,
   parameter int ROW_ID_WIDTH = ROW_ID_WIDTH_DEF
);

   logic                    o_coord_valid;
   logic                    i_coord_ready;
   logic [ADDR_WIDTH-1:0]   o_o_x;
   logic [ADDR_WIDTH-1:0]   o_o_y;
   logic [CH_WIDTH-1:0]     o_ch;
   logic [ROW_ID_WIDTH-1:0] o_row_id;

   modport master (
      output o_coord_valid,
      output o_o_x,
      output o_o_y,
      output o_ch,
      output o_row_id,
      input  i_coord_ready
   );

   modport slave (
      input  o_coord_valid,
      input  o_o_x,
      input  o_o_y,
      input  o_ch,
      input  o_row_id,
      output i_coord_ready
   );

endinterface

// File: rtl/tiled_router_controller_coord_counter.sv
// -----------------------------------------------------------------------------
// router_coord_counter
// Nested output-map walker: y counts fastest, then x, then channel. Also keeps
// the row-router index for the current batch.
//   clk, srst           : clock, synchronous active-high reset
//   load                : latch sizes (minus one) and zero all counters
//   advance             : one coordinate was accepted, step to the next
//   clear_row           : restart row_id at 0 for a new batch
//   size_w/size_h/size_c: map sizes, sampled on load
//   x, y, ch, row_id    : current coordinate (registered)
//   last_coord          : current coordinate is the final one of the map
//   batch_end           : accepting the current coordinate closes the batch
// -----------------------------------------------------------------------------
module router_coord_counter
   import router_pkg::*;
#(
   parameter int ROW_COUNT    = ROW_COUNT_DEF,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int CH_WIDTH     = CH_WIDTH_DEF,
   parameter int ROW_ID_WIDTH = row_id_width(ROW_COUNT)
) (
   input  logic                    clk,
   input  logic                    srst,
   input  logic                    load,
   input  logic                    advance,
   input  logic                    clear_row,
   input  logic [ADDR_WIDTH-1:0]   size_w,
   input  logic [ADDR_WIDTH-1:0]   size_h,
   input  logic [CH_WIDTH-1:0]     size_c,
   output logic [ADDR_WIDTH-1:0]   x,
   output logic [ADDR_WIDTH-1:0]   y,
   output logic [CH_WIDTH-1:0]     ch,
   output logic [ROW_ID_WIDTH-1:0] row_id,
   output logic                    last_coord,
   output logic                    batch_end
);

   localparam logic [ROW_ID_WIDTH-1:0] ROW_LAST = ROW_ID_WIDTH'(ROW_COUNT - 1);

   // Sizes are held as size-1 so every wrap test is a plain equality at full
   // width; a size of 2^N-1 never needs an extra bit. A zero size wraps here,
   // but the FSM never walks a map with a zero dimension.
   logic [ADDR_WIDTH-1:0]   w_m1_reg;
   logic [ADDR_WIDTH-1:0]   h_m1_reg;
   logic [CH_WIDTH-1:0]     c_m1_reg;
   logic [ADDR_WIDTH-1:0]   x_reg;
   logic [ADDR_WIDTH-1:0]   y_reg;
   logic [CH_WIDTH-1:0]     ch_reg;
   logic [ROW_ID_WIDTH-1:0] row_id_reg;

   always_ff @(posedge clk) begin
      if (srst) begin
         w_m1_reg   <= '0;
         h_m1_reg   <= '0;
         c_m1_reg   <= '0;
         x_reg      <= '0;
         y_reg      <= '0;
         ch_reg     <= '0;
         row_id_reg <= '0;
      end else if (load) begin
         w_m1_reg   <= size_w - ADDR_WIDTH'(1);
         h_m1_reg   <= size_h - ADDR_WIDTH'(1);
         c_m1_reg   <= size_c - CH_WIDTH'(1);
         x_reg      <= '0;
         y_reg      <= '0;
         ch_reg     <= '0;
         row_id_reg <= '0;
      end else begin
         if (advance) begin
            if (y_reg != h_m1_reg) begin
               y_reg <= y_reg + ADDR_WIDTH'(1);
            end else begin
               y_reg <= '0;
               if (x_reg != w_m1_reg) begin
                  x_reg <= x_reg + ADDR_WIDTH'(1);
               end else begin
                  x_reg <= '0;
                  // After the final coordinate the walk folds back to the
                  // origin rather than running past the map.
                  if (ch_reg != c_m1_reg) begin
                     ch_reg <= ch_reg + CH_WIDTH'(1);
                  end else begin
                     ch_reg <= '0;
                  end
               end
            end
            // Holds at the last router until the batch is cleared, so a
            // non-power-of-two ROW_COUNT never shows an out-of-range index.
            if (row_id_reg != ROW_LAST) begin
               row_id_reg <= row_id_reg + ROW_ID_WIDTH'(1);
            end
         end
         if (clear_row) begin
            row_id_reg <= '0;
         end
      end
   end

   assign x          = x_reg;
   assign y          = y_reg;
   assign ch         = ch_reg;
   assign row_id     = row_id_reg;
   assign last_coord = (x_reg == w_m1_reg) && (y_reg == h_m1_reg) && (ch_reg == c_m1_reg);
   assign batch_end  = (row_id_reg == ROW_LAST) || last_coord;

endmodule

// File: rtl/tiled_router_controller.sv
// -----------------------------------------------------------------------------
// tiled_router_controller
// Successor sequencer for the row-router array. Walks a W x H x C output map,
// issues coordinates in batches of up to ROW_COUNT rows, then runs the tile
// compare phase, the data-out phase and a router clear before the next batch.
// Ports:
//   i_clk, i_rst        : clock, synchronous active-high reset
//   i_start             : start pulse, honoured only when idle
//   i_reg_clear         : synchronous abort, same effect as i_rst
//   i_o_w, i_o_h        : output width/height, latched in LOAD
//   i_ch_count          : channel count, latched in LOAD
//   coord (master)      : coordinate valid/ready handshake to address generator
//   o_tile_read_en      : tile reader enable (COMPARE)
//   o_ac_en             : address comparator enable (COMPARE)
//   i_addr_empty        : router address queues empty
//   o_pop_en            : row-router data pop enable (DRAIN)
//   i_data_empty        : router data FIFOs empty
//   o_reg_clear         : one-cycle router clear pulse (CLEAR)
//   o_busy              : high in every state except IDLE
//   o_done              : one-cycle completion pulse
// Optional (macro TILED_ROUTER_CTRL_PERF_EN):
//   o_stall_cycles      : GEN cycles with valid high and ready low, saturating
//   o_batch_count       : completed CLEAR states, saturating
// -----------------------------------------------------------------------------
module tiled_router_controller
   import router_pkg::*;
#(
   parameter int ROW_COUNT  = ROW_COUNT_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int CH_WIDTH   = CH_WIDTH_DEF
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_start,
   input  logic                  i_reg_clear,
   input  logic [ADDR_WIDTH-1:0] i_o_w,
   input  logic [ADDR_WIDTH-1:0] i_o_h,
   input  logic [CH_WIDTH-1:0]   i_ch_count,
   tiled_router_controller_if.master coord,
   output logic                  o_tile_read_en,
   output logic                  o_ac_en,
   input  logic                  i_addr_empty,
   output logic                  o_pop_en,
   input  logic                  i_data_empty,
   output logic                  o_reg_clear,
   output logic                  o_busy,
   output logic                  o_done
`ifdef TILED_ROUTER_CTRL_PERF_EN
   ,
   output logic [31:0]           o_stall_cycles,
   output logic [15:0]           o_batch_count
`endif
);

   localparam int ROW_ID_WIDTH = row_id_width(ROW_COUNT);

   // The abort input behaves exactly like reset, so both feed one clear.
   logic srst;
   assign srst = i_rst | i_reg_clear;

   state_t state_reg;
   logic   coord_valid_reg;
   logic   tile_read_en_reg;
   logic   ac_en_reg;
   logic   pop_en_reg;
   logic   reg_clear_reg;
   logic   busy_reg;
   logic   done_reg;
   // Marks the first cycle of COMPARE/DRAIN, which may never be an exit.
   logic   first_reg;
   // Set once the final coordinate of the map has been accepted.
   logic   final_reg;

   logic                    handshake;
   logic                    zero_size;
   logic [ADDR_WIDTH-1:0]   cnt_x;
   logic [ADDR_WIDTH-1:0]   cnt_y;
   logic [CH_WIDTH-1:0]     cnt_ch;
   logic [ROW_ID_WIDTH-1:0] cnt_row_id;
   logic                    cnt_last_coord;
   logic                    cnt_batch_end;

   assign handshake = (state_reg == GEN) && coord_valid_reg && coord.i_coord_ready;
   assign zero_size = (i_o_w == '0) || (i_o_h == '0) || (i_ch_count == '0);

   router_coord_counter #(
      .ROW_COUNT    (ROW_COUNT),
      .ADDR_WIDTH   (ADDR_WIDTH),
      .CH_WIDTH     (CH_WIDTH),
      .ROW_ID_WIDTH (ROW_ID_WIDTH)
   ) u_coord_counter (
      .clk        (i_clk),
      .srst       (srst),
      .load       (state_reg == LOAD),
      .advance    (handshake),
      .clear_row  (state_reg == CLEAR),
      .size_w     (i_o_w),
      .size_h     (i_o_h),
      .size_c     (i_ch_count),
      .x          (cnt_x),
      .y          (cnt_y),
      .ch         (cnt_ch),
      .row_id     (cnt_row_id),
      .last_coord (cnt_last_coord),
      .batch_end  (cnt_batch_end)
   );

   always_ff @(posedge i_clk) begin
      if (srst) begin
         state_reg        <= IDLE;
         coord_valid_reg  <= 1'b0;
         tile_read_en_reg <= 1'b0;
         ac_en_reg        <= 1'b0;
         pop_en_reg       <= 1'b0;
         reg_clear_reg    <= 1'b0;
         busy_reg         <= 1'b0;
         done_reg         <= 1'b0;
         first_reg        <= 1'b0;
         final_reg        <= 1'b0;
      end else begin
         reg_clear_reg <= 1'b0;
         done_reg      <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (i_start) begin
                  state_reg <= LOAD;
                  busy_reg  <= 1'b1;
               end
            end
            LOAD: begin
               final_reg <= 1'b0;
               if (zero_size) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end else begin
                  state_reg       <= GEN;
                  coord_valid_reg <= 1'b1;
               end
            end
            GEN: begin
               if (handshake) begin
                  if (cnt_last_coord) begin
                     final_reg <= 1'b1;
                  end
                  if (cnt_batch_end) begin
                     state_reg        <= COMPARE;
                     coord_valid_reg  <= 1'b0;
                     tile_read_en_reg <= 1'b1;
                     ac_en_reg        <= 1'b1;
                     first_reg        <= 1'b1;
                  end
               end
            end
            COMPARE: begin
               if (first_reg) begin
                  first_reg <= 1'b0;
               end else if (i_addr_empty) begin
                  state_reg        <= DRAIN;
                  tile_read_en_reg <= 1'b0;
                  ac_en_reg        <= 1'b0;
                  pop_en_reg       <= 1'b1;
                  first_reg        <= 1'b1;
               end
            end
            DRAIN: begin
               if (first_reg) begin
                  first_reg <= 1'b0;
               end else if (i_data_empty) begin
                  state_reg     <= CLEAR;
                  pop_en_reg    <= 1'b0;
                  reg_clear_reg <= 1'b1;
               end
            end
            CLEAR: begin
               if (final_reg) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end else begin
                  state_reg       <= GEN;
                  coord_valid_reg <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign coord.o_coord_valid = coord_valid_reg;
   assign coord.o_o_x         = cnt_x;
   assign coord.o_o_y         = cnt_y;
   assign coord.o_ch          = cnt_ch;
   assign coord.o_row_id      = cnt_row_id;
   assign o_tile_read_en      = tile_read_en_reg;
   assign o_ac_en             = ac_en_reg;
   assign o_pop_en            = pop_en_reg;
   assign o_reg_clear         = reg_clear_reg;
   assign o_busy              = busy_reg;
   assign o_done              = done_reg;

`ifdef TILED_ROUTER_CTRL_PERF_EN
   logic [31:0] stall_cycles_reg;
   logic [15:0] batch_count_reg;

   always_ff @(posedge i_clk) begin
      if (srst || (state_reg == LOAD)) begin
         stall_cycles_reg <= '0;
         batch_count_reg  <= '0;
      end else begin
         if ((state_reg == GEN) && coord_valid_reg && !coord.i_coord_ready &&
             (stall_cycles_reg != '1)) begin
            stall_cycles_reg <= stall_cycles_reg + 32'd1;
         end
         if ((state_reg == CLEAR) && (batch_count_reg != '1)) begin
            batch_count_reg <= batch_count_reg + 16'd1;
         end
      end
   end

   assign o_stall_cycles = stall_cycles_reg;
   assign o_batch_count  = batch_count_reg;
`endif

endmodule

// File: tb/tb_tiled_router_controller.sv
// -----------------------------------------------------------------------------
// tb_tiled_router_controller
// Directed and randomized bench for tiled_router_controller (ROW_COUNT=4,
// ADDR_WIDTH=8, CH_WIDTH=4). Expected coordinate sequences and batch shapes
// are computed from the map sizes with plain loops.
// Optional macro TILED_ROUTER_CTRL_PERF_EN adds the performance counter checks.
// -----------------------------------------------------------------------------
module tb_tiled_router_controller;
   import router_pkg::*;

   localparam int ROWS = 4;

   logic       clk;
   logic       i_rst;
   logic       i_start;
   logic       i_reg_clear;
   logic [7:0] i_o_w;
   logic [7:0] i_o_h;
   logic [3:0] i_ch_count;
   logic       o_tile_read_en;
   logic       o_ac_en;
   logic       i_addr_empty;
   logic       o_pop_en;
   logic       i_data_empty;
   logic       o_reg_clear;
   logic       o_busy;
   logic       o_done;
`ifdef TILED_ROUTER_CTRL_PERF_EN
   logic [31:0] o_stall_cycles;
   logic [15:0] o_batch_count;
`endif

   tiled_router_controller_if #(.ADDR_WIDTH(8), .CH_WIDTH(4), .ROW_ID_WIDTH(2)) cif ();

   tiled_router_controller #(.ROW_COUNT(ROWS), .ADDR_WIDTH(8), .CH_WIDTH(4)) dut (
      .i_clk          (clk),
      .i_rst          (i_rst),
      .i_start        (i_start),
      .i_reg_clear    (i_reg_clear),
      .i_o_w          (i_o_w),
      .i_o_h          (i_o_h),
      .i_ch_count     (i_ch_count),
      .coord          (cif),
      .o_tile_read_en (o_tile_read_en),
      .o_ac_en        (o_ac_en),
      .i_addr_empty   (i_addr_empty),
      .o_pop_en       (o_pop_en),
      .i_data_empty   (i_data_empty),
      .o_reg_clear    (o_reg_clear),
      .o_busy         (o_busy),
      .o_done         (o_done)
`ifdef TILED_ROUTER_CTRL_PERF_EN
      ,
      .o_stall_cycles (o_stall_cycles),
      .o_batch_count  (o_batch_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- handshake-side drivers ----------------
   bit rand_ready = 1'b0;
   bit rand_empty = 1'b0;

   initial begin
      cif.i_coord_ready = 1'b1;
      i_addr_empty      = 1'b1;
      i_data_empty      = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         cif.i_coord_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
         i_addr_empty      = rand_empty ? ($urandom_range(0, 2) == 0) : 1'b1;
         i_data_empty      = rand_empty ? ($urandom_range(0, 2) == 0) : 1'b1;
      end
   end

   // ---------------- monitor (append-only records) ----------------
   coord_t hs_q[$];
   int     clr_hs_q[$];
   int     cmp_len_q[$];
   int     drn_len_q[$];
   int     clr_len_q[$];
   int     hs_total  = 0;
   int     done_cnt  = 0;
   int     stall_cnt = 0;
   int     stab_err  = 0;
   int     cmp_run   = 0;
   int     drn_run   = 0;
   int     clr_run   = 0;
   logic   prev_stall = 1'b0;
   coord_t prev_c;
   coord_t mon_cur;

   always @(negedge clk) begin
      mon_cur.x      = cif.o_o_x;
      mon_cur.y      = cif.o_o_y;
      mon_cur.ch     = cif.o_ch;
      mon_cur.row_id = cif.o_row_id;
      if (prev_stall && (cif.o_coord_valid !== 1'b1 || mon_cur !== prev_c)) stab_err++;
      prev_stall = (cif.o_coord_valid === 1'b1) && (cif.i_coord_ready === 1'b0) &&
                   !i_reg_clear && !i_rst;
      prev_c = mon_cur;
      if (cif.o_coord_valid === 1'b1 && cif.i_coord_ready === 1'b1) begin
         hs_q.push_back(mon_cur);
         hs_total++;
      end
      if (cif.o_coord_valid === 1'b1 && cif.i_coord_ready === 1'b0) stall_cnt++;
      if (o_reg_clear === 1'b1) clr_hs_q.push_back(hs_total);
      if (o_done === 1'b1) done_cnt++;
      if (o_tile_read_en === 1'b1) cmp_run++;
      else if (cmp_run > 0) begin cmp_len_q.push_back(cmp_run); cmp_run = 0; end
      if (o_pop_en === 1'b1) drn_run++;
      else if (drn_run > 0) begin drn_len_q.push_back(drn_run); drn_run = 0; end
      if (o_reg_clear === 1'b1) clr_run++;
      else if (clr_run > 0) begin clr_len_q.push_back(clr_run); clr_run = 0; end
   end

   // ---------------- one full map run against the reference model ----------------
   task automatic run_map(input int w, input int h, input int c,
                          input bit rr, input bit re, input bit poke);
      coord_t exp_q[$];
      coord_t e;
      int n, nb, prev_hs, bsz;
      int hs_base, clr_base, done_base, stall_base, stab_base;
      int cmp_base, drn_base, clw_base;

      hs_base    = hs_q.size();
      clr_base   = clr_hs_q.size();
      done_base  = done_cnt;
      stall_base = stall_cnt;
      stab_base  = stab_err;
      cmp_base   = cmp_len_q.size();
      drn_base   = drn_len_q.size();
      clw_base   = clr_len_q.size();

      // Reference: y fastest, then x, then channel; row = position in batch.
      n = 0;
      for (int ci = 0; ci < c; ci++)
         for (int xi = 0; xi < w; xi++)
            for (int yi = 0; yi < h; yi++) begin
               e.x      = 8'(xi);
               e.y      = 8'(yi);
               e.ch     = 4'(ci);
               e.row_id = 2'(n % ROWS);
               exp_q.push_back(e);
               n++;
            end
      nb = (n + ROWS - 1) / ROWS;

      rand_ready = rr;
      rand_empty = re;
      i_o_w      = 8'(w);
      i_o_h      = 8'(h);
      i_ch_count = 4'(c);
      @(posedge clk); #1;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      check("load_busy", 64'(o_busy), 64'd1);
      check("load_valid", 64'(cif.o_coord_valid), 64'd0);
      @(posedge clk); #1;
      if (n == 0) check("empty_done", 64'(o_done), 64'd1);
      else        check("first_valid", 64'(cif.o_coord_valid), 64'd1);

      if (poke && n > 0) begin
         // Start with different sizes while busy must change nothing.
         @(posedge clk); #1;
         i_o_w      = 8'(w + 3);
         i_o_h      = 8'(h + 2);
         i_ch_count = 4'(c + 1);
         i_start    = 1'b1;
         @(posedge clk); #1;
         i_start = 1'b0;
      end

      for (int k = 0; k < 4000 && done_cnt == done_base; k++) begin
         @(posedge clk); #1;
      end
      check("done_pulses", 64'(done_cnt - done_base), 64'd1);
      @(posedge clk); #1;
      check("idle_busy", 64'(o_busy), 64'd0);
      check("idle_done", 64'(o_done), 64'd0);

      check("coord_count", 64'(hs_q.size() - hs_base), 64'(n));
      for (int i = 0; i < n; i++) begin
         if (hs_base + i < hs_q.size())
            check($sformatf("coord[%0d]", i), 64'(hs_q[hs_base + i]), 64'(exp_q[i]));
      end
      check("clear_pulses", 64'(clr_hs_q.size() - clr_base), 64'(nb));
      prev_hs = hs_base;
      for (int b = 0; b < nb; b++) begin
         if (clr_base + b < clr_hs_q.size()) begin
            bsz = (n - b * ROWS < ROWS) ? (n - b * ROWS) : ROWS;
            check($sformatf("batch_size[%0d]", b),
                  64'(clr_hs_q[clr_base + b] - prev_hs), 64'(bsz));
            prev_hs = clr_hs_q[clr_base + b];
         end
      end
      check("stable_while_stalled", 64'(stab_err - stab_base), 64'd0);
      check("compare_phases", 64'(cmp_len_q.size() - cmp_base), 64'(nb));
      check("drain_phases", 64'(drn_len_q.size() - drn_base), 64'(nb));
      for (int b = 0; b < nb; b++) begin
         if (cmp_base + b < cmp_len_q.size() && drn_base + b < drn_len_q.size() &&
             clw_base + b < clr_len_q.size()) begin
            if (re) begin
               check("compare_min_len", 64'(cmp_len_q[cmp_base + b] >= 2), 64'd1);
               check("drain_min_len", 64'(drn_len_q[drn_base + b] >= 2), 64'd1);
            end else begin
               check("compare_len", 64'(cmp_len_q[cmp_base + b]), 64'd2);
               check("drain_len", 64'(drn_len_q[drn_base + b]), 64'd2);
            end
            check("clear_len", 64'(clr_len_q[clw_base + b]), 64'd1);
         end
      end
`ifdef TILED_ROUTER_CTRL_PERF_EN
      check("perf_stalls", 64'(o_stall_cycles), 64'(stall_cnt - stall_base));
      check("perf_batches", 64'(o_batch_count), 64'(nb));
`endif
      $display("run W=%0d H=%0d C=%0d rand_ready=%0d rand_empty=%0d: %0d coords, %0d batches",
               w, h, c, rr, re, n, nb);
   endtask

   // ---------------- directed sequence ----------------
   int hs_mark;

   initial begin
      i_rst       = 1'b1;
      i_start     = 1'b0;
      i_reg_clear = 1'b0;
      i_o_w       = 8'd0;
      i_o_h       = 8'd0;
      i_ch_count  = 4'd0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", 64'(cif.o_coord_valid), 64'd0);
      check("rst_busy", 64'(o_busy), 64'd0);
      check("rst_done", 64'(o_done), 64'd0);
      check("rst_clear", 64'(o_reg_clear), 64'd0);
      check("rst_coord", 64'({cif.o_o_x, cif.o_o_y, cif.o_ch, cif.o_row_id}), 64'd0);
      i_rst = 1'b0;

      // Plan maps with ready always high.
      run_map(2, 2, 1, 1'b0, 1'b0, 1'b0);
      run_map(3, 2, 2, 1'b0, 1'b0, 1'b0);
      run_map(3, 1, 1, 1'b0, 1'b0, 1'b0);
      // Same map under a randomly toggled ready.
      run_map(3, 2, 2, 1'b1, 1'b0, 1'b0);

      // Empty map, with a start coinciding with o_done.
      hs_mark    = hs_q.size();
      i_o_w      = 8'd0;
      i_o_h      = 8'd3;
      i_ch_count = 4'd2;
      @(posedge clk); #1;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      check("w0_cycle1_done", 64'(o_done), 64'd0);
      @(posedge clk); #1;
      check("w0_cycle2_done", 64'(o_done), 64'd1);
      check("w0_valid", 64'(cif.o_coord_valid), 64'd0);
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      check("w0_start_on_done_ignored", 64'(o_busy), 64'd0);
      check("w0_done_one_cycle", 64'(o_done), 64'd0);
      @(posedge clk); #1;
      check("w0_still_idle", 64'(o_busy), 64'd0);
      check("w0_no_coords", 64'(hs_q.size() - hs_mark), 64'd0);

      // Zero height through the full-run path.
      run_map(2, 0, 1, 1'b0, 1'b0, 1'b0);

      // Abort mid-GEN.
      i_o_w      = 8'd3;
      i_o_h      = 8'd2;
      i_ch_count = 4'd2;
      @(posedge clk); #1;
      i_start = 1'b1;
      @(posedge clk); #1;
      i_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("abort_in_gen", 64'(cif.o_coord_valid), 64'd1);
      i_reg_clear = 1'b1;
      @(posedge clk); #1;
      i_reg_clear = 1'b0;
      check("abort_valid", 64'(cif.o_coord_valid), 64'd0);
      check("abort_coord", 64'({cif.o_o_x, cif.o_o_y, cif.o_ch, cif.o_row_id}), 64'd0);
      check("abort_enables", 64'({o_tile_read_en, o_ac_en, o_pop_en, o_reg_clear}), 64'd0);
      check("abort_busy", 64'(o_busy), 64'd0);
      check("abort_done", 64'(o_done), 64'd0);
      run_map(3, 2, 2, 1'b0, 1'b0, 1'b0);

      // Randomized maps; one run also pokes start while busy.
      for (int k = 0; k < 6; k++) begin
         run_map($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 3),
                 1'b1, k[0], k == 1);
      end

      rand_ready = 1'b0;
      rand_empty = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/tiled_router_controller.md
# tiled_router_controller

Parametrised successor sequencer for the row-router array. It walks a rectangular, multi-channel output feature map (W × H × C) and issues output coordinates to the address generator over a valid/ready handshake, in batches of up to ROW_COUNT rows. After each batch it runs the tile-comparison phase and then the data-out phase, and clears the routers before the next batch. It sits between the layer scheduler (start/done) and the address generator, address comparator, tile reader and row-router output FIFOs.

## Interface
- ROW_COUNT, 4: row routers per batch (≥1)
- ADDR_WIDTH, 8: coordinate/size width
- CH_WIDTH, 4: channel index/count width
- i_clk  in  1  clock, rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start  in  1  start pulse; ignored unless idle
- i_reg_clear  in  1  synchronous abort; same effect as i_rst
- i_o_w, i_o_h  in  ADDR_WIDTH  output width/height, latched on start
- i_ch_count  in  CH_WIDTH  channel count, latched on start
- o_coord_valid  out  1  coordinate valid to address generator
- i_coord_ready  in  1  address generator accepts coordinate
- o_o_x, o_o_y  out  ADDR_WIDTH  output coordinate
- o_ch  out  CH_WIDTH  channel index
- o_row_id  out  $clog2(ROW_COUNT) (min 1)  target row router
- o_tile_read_en, o_ac_en  out  1  tile reader / address comparator enable
- i_addr_empty  in  1  router address queues empty
- o_pop_en  out  1  row-router data pop enable
- i_data_empty  in  1  router data FIFOs empty
- o_reg_clear  out  1  one-cycle router clear pulse
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle completion pulse

## Operation
- All outputs are registered. Reset and i_reg_clear drive every output to 0, counters to 0 and the FSM to IDLE. This applies at any point, mid-batch included.
- States and transitions:
  - IDLE → LOAD on i_start.
  - LOAD → GEN, or → DONE if any of W, H or C is 0.
  - GEN → COMPARE after the last handshake of a batch.
  - COMPARE → DRAIN.
  - DRAIN → CLEAR.
  - CLEAR → GEN if coordinates remain, else → DONE.
  - DONE → IDLE.
- LOAD latches W, H and C and zeroes x, y, ch and row_id.
- Traversal order: y fastest, then x, then ch, i.e. (x0,y0,c0), (x0,y1,c0), …
- GEN holds o_coord_valid with stable coordinates until i_coord_ready. On each handshake the counters advance and row_id increments.
- A batch ends on the handshake where row_id == ROW_COUNT-1 or the coordinate is the final one (x=W-1, y=H-1, ch=C-1). A final batch may be partial.
- COMPARE asserts o_tile_read_en and o_ac_en. It exits on the first cycle that i_addr_empty is sampled high while the enables are already high; the entry cycle is never an exit.
- DRAIN uses the same rule with o_pop_en and i_data_empty.
- CLEAR pulses o_reg_clear for exactly one cycle and resets row_id to 0.
- DONE pulses o_done for one cycle.
- Counter compares use latched size minus 1, evaluated at full width. W, H = 2^ADDR_WIDTH-1 are legal; counters never wrap silently.

## Timing
- Start latency: i_start at cycle 0 → LOAD at cycle 1 → first o_coord_valid at cycle 2.
- With i_coord_ready held high, one coordinate is issued per cycle.
- COMPARE is entered the cycle after the last handshake of the batch. Enables fall the cycle after the exit condition is sampled.
- Minimum batch overhead is 2 COMPARE cycles + 2 DRAIN cycles + 1 CLEAR cycle.
- Empty map: i_start → LOAD → DONE, so o_done pulses at cycle 2 and no coordinate is ever issued.
- o_done and i_start in the same cycle: the FSM returns to IDLE first, so the new start is ignored.
- i_start while o_busy: ignored, and latched sizes are unchanged.
- Ready dropping mid-batch: valid and coordinates hold, no skipped or duplicated coordinates.

## Configuration
- TILED_ROUTER_CTRL_PERF_EN defined:
  - Adds output o_stall_cycles [31:0], which counts GEN cycles with o_coord_valid && !i_coord_ready.
  - Adds output o_batch_count [15:0], which counts completed CLEAR states.
  - Both counters clear on LOAD, reset and i_reg_clear, and saturate at their maximum.
- Undefined: neither port nor either counter exists, and all other behaviour is identical.

## Structure
- Shared package router_pkg holds:
  - the state enum typedef (IDLE, LOAD, GEN, COMPARE, DRAIN, CLEAR, DONE);
  - a coordinate struct typedef {x, y, ch, row_id};
  - a localparam helper for the row_id width.
- One sub-module, router_coord_counter: the nested y/x/ch counter with row_id, exposing advance, load and clear inputs plus last_coord and batch_end flags. The FSM stays in the top.

## Test plan
- Map 2×2×1, ROW_COUNT=4, ready always high:
  - Coordinates issued in order (0,0),(0,1),(1,0),(1,1) with row_id 0..3.
  - One COMPARE/DRAIN/CLEAR sequence follows.
  - o_done pulses once.
- Map 3×2×2, ROW_COUNT=4:
  - 12 coordinates in 3 batches, with channel 1 following channel 0.
  - Exactly 3 o_reg_clear pulses, each batch holding 4 coordinates.
- Map 3×1×1, ROW_COUNT=4: one partial batch with row_id 0..2, then o_done.
- Ready toggled randomly:
  - Coordinates are stable while valid && !ready.
  - Sequence is identical to the always-ready run.
  - With PERF_EN, o_stall_cycles equals the number of stall cycles.
- i_addr_empty held high on COMPARE entry: COMPARE lasts exactly 2 cycles. Same check for DRAIN with i_data_empty.
- i_reg_clear asserted mid-GEN: the next cycle all outputs are 0 and the FSM is IDLE. A fresh i_start restarts from (0,0,0).
- W=0: o_done pulses 2 cycles after i_start with no o_coord_valid.
